// File: rtl/masked_serial_loader.sv
// -----------------------------------------------------------------------------
// masked_serial_loader
//
// Byte-serial front-end for a masked serial AES core. A shared plaintext/key
// block is accepted over a valid/ready handshake, fed to the core one word per
// cycle (optionally re-masked with fresh randomness), the core is released,
// and the shared ciphertext words are collected back into a parallel result.
// Shares are never combined with each other anywhere in this block.
//
// Parameters:
//   SHARES  : number of Boolean shares (2..4)
//   W       : bits per serial word
//   BYTES   : words per block (>= 2)
//   REMASK  : 1 = refresh every serialised word with rnd_in, 0 = pass through
//   TIMEOUT : maximum RUN cycles before the transfer is aborted (>= 2)
//
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   in_valid/in_ready : input handshake (in_ready high only in IDLE)
//   pt_sh, key_sh     : plaintext/key shares, share s at [(s+1)*BYTES*W-1 -: BYTES*W],
//                       word 0 in the top W bits of each share
//   rnd_in            : per-cycle randomness, low half plaintext, high half key
//   core_rst          : active-high hold of the core
//   core_pt, core_key : current word of every share, share s at [(s+1)*W-1 -: W]
//   core_out          : serial ciphertext shares from the core
//   core_done         : core flags the first ciphertext word
//   out_valid/out_ready : output handshake
//   ct_sh             : collected ciphertext shares, same packing as pt_sh
//   err               : sticky timeout flag, cleared on the next accept
// -----------------------------------------------------------------------------
module masked_serial_loader #(
    parameter int SHARES  = 2,
    parameter int W       = 8,
    parameter int BYTES   = 16,
    parameter int REMASK  = 1,
    parameter int TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [SHARES*BYTES*W-1:0]    pt_sh,
    input  logic [SHARES*BYTES*W-1:0]    key_sh,
    input  logic [2*(SHARES-1)*W-1:0]    rnd_in,
    output logic                         core_rst,
    output logic [SHARES*W-1:0]          core_pt,
    output logic [SHARES*W-1:0]          core_key,
    input  logic [SHARES*W-1:0]          core_out,
    input  logic                         core_done,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [SHARES*BYTES*W-1:0]    ct_sh,
    output logic                         err
);

    localparam int BW   = BYTES * W;
    localparam int RW   = (SHARES - 1) * W;
    localparam int MAXC = (BYTES > TIMEOUT) ? BYTES : TIMEOUT;
    localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

    localparam logic [CW-1:0] LAST_WORD   = CW'(BYTES - 1);
    localparam logic [CW-1:0] LAST_UNLOAD = CW'(BYTES - 2);
    localparam logic [CW-1:0] LAST_RUN    = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        RUN    = 3'd2,
        UNLOAD = 3'd3,
        HOLD   = 3'd4
    } state_t;

    state_t                 state_r;
    logic [CW-1:0]          cnt_r;
    logic [SHARES*BW-1:0]   pt_r;
    logic [SHARES*BW-1:0]   key_r;
    logic [SHARES*W-1:0]    pt_raw_s;
    logic [SHARES*W-1:0]    key_raw_s;
    logic [SHARES*W-1:0]    pt_word_s;
    logic [SHARES*W-1:0]    key_word_s;

    // Top word of every share of a packed shift register.
    function automatic logic [SHARES*W-1:0] top_words(input logic [SHARES*BW-1:0] sh);
        logic [SHARES*W-1:0] res;
        res = '0;
        for (int s = 0; s < SHARES; s++) begin
            res[s*W +: W] = sh[s*BW + BW - W +: W];
        end
        return res;
    endfunction

    // Refresh one word of all shares: share s>=1 takes slice s-1, share 0 takes
    // the XOR of all slices, so the XOR over shares is preserved. Only
    // randomness is ever mixed into a share, never another share.
    function automatic logic [SHARES*W-1:0] remask(input logic [SHARES*W-1:0] words,
                                                   input logic [RW-1:0]       rnd);
        logic [SHARES*W-1:0] res;
        logic [W-1:0]        acc;
        res = words;
        acc = '0;
        for (int s = 1; s < SHARES; s++) begin
            res[s*W +: W] = res[s*W +: W] ^ rnd[(s-1)*W +: W];
            acc           = acc ^ rnd[(s-1)*W +: W];
        end
        res[W-1:0] = res[W-1:0] ^ acc;
        return res;
    endfunction

    // Advance every share by one word, filling with zeros.
    function automatic logic [SHARES*BW-1:0] shift_out(input logic [SHARES*BW-1:0] sh);
        logic [SHARES*BW-1:0] res;
        res = '0;
        for (int s = 0; s < SHARES; s++) begin
            res[s*BW +: BW] = {sh[s*BW +: BW-W], {W{1'b0}}};
        end
        return res;
    endfunction

    // Append one word per share at the bottom; after BYTES calls word 0 is on top.
    function automatic logic [SHARES*BW-1:0] shift_in(input logic [SHARES*BW-1:0] sh,
                                                      input logic [SHARES*W-1:0]  words);
        logic [SHARES*BW-1:0] res;
        res = '0;
        for (int s = 0; s < SHARES; s++) begin
            res[s*BW +: BW] = {sh[s*BW +: BW-W], words[s*W +: W]};
        end
        return res;
    endfunction

    assign pt_raw_s  = top_words(pt_r);
    assign key_raw_s = top_words(key_r);

    // Serial word presented to the core; randomness is used in the same cycle
    // it arrives, so this path is combinational from rnd_in.
    always_comb begin
        pt_word_s  = pt_raw_s;
        key_word_s = key_raw_s;
        core_pt    = '0;
        core_key   = '0;
        if (REMASK != 0) begin
            pt_word_s  = remask(pt_raw_s, rnd_in[RW-1:0]);
            key_word_s = remask(key_raw_s, rnd_in[2*RW-1:RW]);
        end else begin
            pt_word_s  = pt_raw_s;
            key_word_s = key_raw_s;
        end
        if (state_r == LOAD) begin
            core_pt  = pt_word_s;
            core_key = key_word_s;
        end else begin
            core_pt  = '0;
            core_key = '0;
        end
    end

    // Control FSM, shift registers and registered handshake outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r   <= IDLE;
            cnt_r     <= '0;
            pt_r      <= '0;
            key_r     <= '0;
            in_ready  <= 1'b1;
            core_rst  <= 1'b1;
            out_valid <= 1'b0;
            ct_sh     <= '0;
            err       <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    core_rst <= 1'b1;
                    if (in_valid) begin
                        pt_r     <= pt_sh;
                        key_r    <= key_sh;
                        err      <= 1'b0;
                        cnt_r    <= '0;
                        in_ready <= 1'b0;
                        state_r  <= LOAD;
                    end else begin
                        in_ready <= 1'b1;
                    end
                end
                LOAD: begin
                    pt_r  <= shift_out(pt_r);
                    key_r <= shift_out(key_r);
                    if (cnt_r == LAST_WORD) begin
                        cnt_r    <= '0;
                        core_rst <= 1'b0;
                        state_r  <= RUN;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                RUN: begin
                    // done is checked first so it wins on the final RUN cycle
                    if (core_done) begin
                        ct_sh   <= shift_in(ct_sh, core_out);
                        cnt_r   <= '0;
                        state_r <= UNLOAD;
                    end else if (cnt_r == LAST_RUN) begin
                        err      <= 1'b1;
                        cnt_r    <= '0;
                        core_rst <= 1'b1;
                        in_ready <= 1'b1;
                        state_r  <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                UNLOAD: begin
                    ct_sh <= shift_in(ct_sh, core_out);
                    if (cnt_r == LAST_UNLOAD) begin
                        cnt_r     <= '0;
                        core_rst  <= 1'b1;
                        out_valid <= 1'b1;
                        state_r   <= HOLD;
                    end else begin
                        cnt_r <= cnt_r + 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_r   <= IDLE;
                    end else begin
                        out_valid <= 1'b1;
                    end
                end
                default: begin
                    state_r   <= IDLE;
                    cnt_r     <= '0;
                    in_ready  <= 1'b1;
                    core_rst  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_masked_serial_loader.sv
// -----------------------------------------------------------------------------
// tb_masked_serial_loader
//
// Directed bench with two instances driven in lockstep:
//   dut_a : SHARES=2, REMASK=0 (plain pass-through of shares)
//   dut_b : SHARES=3, REMASK=1 (per-word refresh from rnd_in)
// Both use TIMEOUT=64. The core is modelled by driving the known FIPS-197
// ciphertext, randomly split into shares, on core_out after core_done.
// -----------------------------------------------------------------------------
module tb_masked_serial_loader;

    localparam int W     = 8;
    localparam int BYTES = 16;
    localparam int TOUT  = 64;

    localparam logic [127:0] PT  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT  = 128'h3925841d02dc09fbdc118597196a0b32;

    logic clk = 1'b0;
    logic rst, in_valid, out_ready, core_done;
    logic [15:0] rnd_a;
    logic [31:0] rnd_b;
    logic [15:0] cout_a;
    logic [23:0] cout_b;

    logic [127:0] pa [2];
    logic [127:0] ka [2];
    logic [127:0] ca [2];
    logic [127:0] pb [3];
    logic [127:0] kb [3];
    logic [127:0] cb [3];

    logic [255:0] pt_a, key_a, ct_a;
    logic [383:0] pt_b, key_b, ct_b;
    logic         in_ready_a, core_rst_a, out_valid_a, err_a;
    logic         in_ready_b, core_rst_b, out_valid_b, err_b;
    logic [15:0]  core_pt_a, core_key_a;
    logic [23:0]  core_pt_b, core_key_b;

    int n_checks = 0;
    int n_pass   = 0;

    assign pt_a  = {pa[1], pa[0]};
    assign key_a = {ka[1], ka[0]};
    assign pt_b  = {pb[2], pb[1], pb[0]};
    assign key_b = {kb[2], kb[1], kb[0]};

    always #5 clk = ~clk;

    masked_serial_loader #(.SHARES(2), .W(W), .BYTES(BYTES), .REMASK(0), .TIMEOUT(TOUT)) dut_a (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_a),
        .pt_sh(pt_a), .key_sh(key_a), .rnd_in(rnd_a), .core_rst(core_rst_a),
        .core_pt(core_pt_a), .core_key(core_key_a), .core_out(cout_a),
        .core_done(core_done), .out_valid(out_valid_a), .out_ready(out_ready),
        .ct_sh(ct_a), .err(err_a)
    );

    masked_serial_loader #(.SHARES(3), .W(W), .BYTES(BYTES), .REMASK(1), .TIMEOUT(TOUT)) dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .pt_sh(pt_b), .key_sh(key_b), .rnd_in(rnd_b), .core_rst(core_rst_b),
        .core_pt(core_pt_b), .core_key(core_key_b), .core_out(cout_b),
        .core_done(core_done), .out_valid(out_valid_b), .out_ready(out_ready),
        .ct_sh(ct_b), .err(err_b)
    );

    task automatic check_eq(input string tag, input logic [383:0] obs, input logic [383:0] expv);
        n_checks++;
        if (obs === expv) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [127:0] v, input int k);
        return v[127-8*k -: 8];
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fresh share splits of the FIPS vector; zero_a forces dut_a share 1 to 0.
    task automatic new_masks(input bit zero_a);
        pa[1] = zero_a ? 128'd0 : rnd128();
        ka[1] = zero_a ? 128'd0 : rnd128();
        ca[1] = zero_a ? 128'd0 : rnd128();
        pa[0] = PT ^ pa[1];
        ka[0] = KEY ^ ka[1];
        ca[0] = CT ^ ca[1];
        for (int s = 1; s < 3; s++) begin
            pb[s] = rnd128();
            kb[s] = rnd128();
            cb[s] = rnd128();
        end
        pb[0] = PT ^ pb[1] ^ pb[2];
        kb[0] = KEY ^ kb[1] ^ kb[2];
        cb[0] = CT ^ cb[1] ^ cb[2];
    endtask

    task automatic check_reset(input string tag);
        check_eq({tag, "_in_ready"}, {in_ready_a, in_ready_b}, 2'b11);
        check_eq({tag, "_core_rst"}, {core_rst_a, core_rst_b}, 2'b11);
        check_eq({tag, "_out_valid"}, {out_valid_a, out_valid_b}, 2'b00);
        check_eq({tag, "_err"}, {err_a, err_b}, 2'b00);
        check_eq({tag, "_core_pt"}, {core_pt_a, core_key_a, core_pt_b, core_key_b}, 80'd0);
        check_eq({tag, "_ct_a"}, ct_a, 256'd0);
        check_eq({tag, "_ct_b"}, ct_b, 384'd0);
    endtask

    // Offer a block in IDLE; returns in the cycle that presents word 0.
    task automatic accept();
        check_eq("idle_in_ready", {in_ready_a, in_ready_b}, 2'b11);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        check_eq("acc_in_ready", {in_ready_a, in_ready_b}, 2'b00);
        check_eq("acc_err_clear", {err_a, err_b}, 2'b00);
    endtask

    task automatic load_phase();
        logic [23:0] exp_pb, exp_kb;
        for (int k = 0; k < BYTES; k++) begin
            rnd_a = 16'($urandom);
            rnd_b = $urandom;
            #1;
            check_eq("load_pt_a", core_pt_a, {byte_of(pa[1], k), byte_of(pa[0], k)});
            check_eq("load_key_a", core_key_a, {byte_of(ka[1], k), byte_of(ka[0], k)});
            exp_pb = {byte_of(pb[2], k) ^ rnd_b[15:8],
                      byte_of(pb[1], k) ^ rnd_b[7:0],
                      byte_of(pb[0], k) ^ rnd_b[7:0] ^ rnd_b[15:8]};
            exp_kb = {byte_of(kb[2], k) ^ rnd_b[31:24],
                      byte_of(kb[1], k) ^ rnd_b[23:16],
                      byte_of(kb[0], k) ^ rnd_b[23:16] ^ rnd_b[31:24]};
            check_eq("load_pt_b", core_pt_b, exp_pb);
            check_eq("load_key_b", core_key_b, exp_kb);
            check_eq("load_pt_b_xor", core_pt_b[23:16] ^ core_pt_b[15:8] ^ core_pt_b[7:0], byte_of(PT, k));
            check_eq("load_core_rst", {core_rst_a, core_rst_b}, 2'b11);
            step();
        end
        check_eq("run_core_rst", {core_rst_a, core_rst_b}, 2'b00);
        check_eq("run_core_pt", {core_pt_a, core_key_a, core_pt_b, core_key_b}, 80'd0);
    endtask

    // core_done is raised in the done_at-th RUN cycle (1-based).
    task automatic run_phase(input int done_at);
        for (int i = 1; i < done_at; i++) begin
            step();
        end
        core_done = 1'b1;
        cout_a = {byte_of(ca[1], 0), byte_of(ca[0], 0)};
        cout_b = {byte_of(cb[2], 0), byte_of(cb[1], 0), byte_of(cb[0], 0)};
        step();
    endtask

    // Stream words 1..BYTES-1; core_done stays high and must be ignored.
    // A nonzero abort_word pulls reset during that word and returns in IDLE.
    task automatic unload_phase(input int abort_word);
        for (int j = 1; j < BYTES; j++) begin
            cout_a = {byte_of(ca[1], j), byte_of(ca[0], j)};
            cout_b = {byte_of(cb[2], j), byte_of(cb[1], j), byte_of(cb[0], j)};
            if (j == abort_word) begin
                rst = 1'b0;
                #1;
                check_reset("abort");
                core_done = 1'b0;
                step();
                rst = 1'b1;
                step();
                return;
            end
            step();
            check_eq("unload_out_valid", {out_valid_a, out_valid_b}, (j == BYTES-1) ? 2'b11 : 2'b00);
        end
        core_done = 1'b0;
    endtask

    task automatic hold_and_release();
        check_eq("hold_ct_a", ct_a, {ca[1], ca[0]});
        check_eq("hold_ct_a_xor", ct_a[255:128] ^ ct_a[127:0], CT);
        check_eq("hold_ct_b", ct_b, {cb[2], cb[1], cb[0]});
        check_eq("hold_ct_b_xor", ct_b[383:256] ^ ct_b[255:128] ^ ct_b[127:0], CT);
        check_eq("hold_in_ready", {in_ready_a, in_ready_b}, 2'b00);
        check_eq("hold_err", {err_a, err_b}, 2'b00);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("release_out_valid", {out_valid_a, out_valid_b}, 2'b00);
        check_eq("release_in_ready", {in_ready_a, in_ready_b}, 2'b11);
    endtask

    task automatic full_txn(input bit zero_a, input int done_at);
        new_masks(zero_a);
        accept();
        load_phase();
        run_phase(done_at);
        unload_phase(0);
        hold_and_release();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [255:0] held_a;
        logic [383:0] held_b;
        rst = 1'b1;
        in_valid = 1'b0;
        out_ready = 1'b0;
        core_done = 1'b0;
        rnd_a = 16'd0;
        rnd_b = 32'd0;
        cout_a = 16'd0;
        cout_b = 24'd0;
        new_masks(1'b1);
        #2 rst = 1'b0;
        step();
        step();
        check_reset("reset");
        rst = 1'b1;
        step();

        // FIPS-197 vector; dut_a share 1 is zero so core_pt_a shows plain bytes
        full_txn(1'b1, 5);
        full_txn(1'b0, 10);

        // Timeout: core never signals done
        new_masks(1'b0);
        accept();
        load_phase();
        for (int i = 1; i < TOUT; i++) begin
            step();
        end
        check_eq("to_before_err", {err_a, err_b, in_ready_a, core_rst_a}, 4'b0000);
        step();
        check_eq("to_err", {err_a, err_b}, 2'b11);
        check_eq("to_idle", {in_ready_a, in_ready_b, core_rst_a, core_rst_b}, 4'b1111);

        // Next accept clears err; done on the last allowed RUN cycle wins
        full_txn(1'b0, TOUT);

        // Stall in HOLD while in_valid toggles with new data on the inputs
        new_masks(1'b0);
        accept();
        load_phase();
        run_phase(3);
        unload_phase(0);
        held_a = {ca[1], ca[0]};
        held_b = {cb[2], cb[1], cb[0]};
        new_masks(1'b0);
        for (int i = 0; i < 20; i++) begin
            in_valid = (i % 2 == 0);
            step();
            check_eq("stall_ct_a", ct_a, held_a);
            check_eq("stall_ct_b", ct_b, held_b);
            check_eq("stall_flags", {in_ready_a, in_ready_b, out_valid_a, out_valid_b}, 4'b0011);
        end
        in_valid = 1'b1;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check_eq("stall_release", {in_ready_a, out_valid_a, out_valid_b}, 3'b100);
        step();
        in_valid = 1'b0;
        check_eq("stall_one_accept", {in_ready_a, in_ready_b}, 2'b00);
        load_phase();
        run_phase(4);
        unload_phase(0);
        hold_and_release();

        // Reset during UNLOAD word 7, then a clean transaction
        new_masks(1'b0);
        accept();
        load_phase();
        run_phase(7);
        unload_phase(7);
        check_reset("post_abort");
        full_txn(1'b0, 20);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/masked_serial_loader.md
# masked_serial_loader

Parametrised byte-serial front-end for the masked serial AES encryption core. Accepts one shared plaintext/key block over a valid/ready handshake and serialises it into the core over `BYTES` cycles, optionally re-masking every byte with fresh randomness. It then releases the core, waits for `core_done`, and deserialises the shared ciphertext bytes back into a parallel result. Shares are never recombined inside the block; it replaces ad-hoc per-byte share driving at the core boundary.

## Interface
- `SHARES`, 2, number of Boolean shares; legal range 2..4.
- `W`, 8, bits per serial word.
- `BYTES`, 16, words per block.
- `REMASK`, 1, 1 = re-mask every serialised word with `rnd_in`; 0 = pass shares through unchanged.
- `TIMEOUT`, 1024, maximum cycles in RUN before abort; must be ≥ 2.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  a block is offered.
- `in_ready`  out  1  high only in IDLE.
- `pt_sh`  in  SHARES*BYTES*W  plaintext shares; share s at bits [(s+1)*BYTES*W-1 : s*BYTES*W]; word 0 in the top W bits of each share.
- `key_sh`  in  SHARES*BYTES*W  key shares, same packing.
- `rnd_in`  in  2*(SHARES-1)*W  fresh randomness per cycle; low half for plaintext, high half for key.
- `core_rst`  out  1  active-high hold of the core.
- `core_pt`  out  SHARES*W  current plaintext word, all shares; share s at [(s+1)*W-1 : s*W].
- `core_key`  out  SHARES*W  current key word, same packing.
- `core_out`  in  SHARES*W  serial ciphertext shares from the core.
- `core_done`  in  1  core marks the first ciphertext word.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts.
- `ct_sh`  out  SHARES*BYTES*W  ciphertext shares, same packing as `pt_sh`.
- `err`  out  1  sticky timeout flag.

## Operation
- States: IDLE, LOAD, RUN, UNLOAD, HOLD.
- IDLE: `in_ready`=1 and `core_rst`=1. When `in_valid`=1, latch `pt_sh` and `key_sh` into the shift registers, clear `err`, set the word counter to 0, and go to LOAD.
- LOAD, for BYTES cycles:
  - Present word k on `core_pt`/`core_key` in cycle k, with `core_rst`=1.
  - After word BYTES-1, go to RUN.
- Re-masking when REMASK=1:
  - Share s≥1 is XORed with rnd slice s-1.
  - Share 0 is XORed with the XOR of all slices.
  - The XOR of all shares is therefore unchanged.
  - `rnd_in` is sampled combinationally in the same cycle. No share is ever XORed with another share.
- RUN:
  - `core_rst`=0. `core_pt`/`core_key` are driven to 0.
  - The cycle counter increments each cycle.
  - If `core_done`=1, capture `core_out` as word 0 and go to UNLOAD.
  - If the counter reaches TIMEOUT-1 without `core_done`, set `err`=1 and return to IDLE.
- UNLOAD: capture words 1..BYTES-1 on consecutive cycles, then go to HOLD.
- HOLD: `out_valid`=1 and `ct_sh` is stable. When `out_ready`=1, go to IDLE.
- `core_done` outside RUN is ignored.
- `in_valid` outside IDLE is ignored. `in_ready`=0 there, so no input is lost.
- Counters are sized to clog2(max(BYTES,TIMEOUT)). The word counter wraps to 0 on each state exit.

## Timing
- Reset values: state IDLE, `in_ready`=1, `core_rst`=1, `core_pt`=0, `core_key`=0, `out_valid`=0, `ct_sh`=0, `err`=0, all counters 0.
- Reset mid-operation aborts immediately to IDLE. Partially captured data is cleared to 0.
- Accept at edge t0. Word 0 appears on `core_pt` during cycle t0+1. Word BYTES-1 appears at t0+BYTES. `core_rst` falls at t0+BYTES+1.
- `core_done` sampled high at edge td: `out_valid` rises at td+BYTES.
- Total latency = 1 + BYTES + (core run cycles) + BYTES.
- Handshake outputs are registered. `out_valid` and `ct_sh` hold until the cycle after `out_ready` is sampled high.
- `core_done` high at the edge where the counter reaches TIMEOUT-1: done wins, and no error is raised.
- `out_ready` held permanently high: HOLD lasts exactly 1 cycle.
- `in_valid`=1 on the return to IDLE: the next accept happens on the first IDLE cycle at the earliest.

## Test plan
- FIPS-197 vector, SHARES=2, REMASK=0, share1=0: pt 3243f6a8885a308d313198a2e0370734 and key 2b7e151628aed2a6abf7158809cf4f3c. Required: `core_pt` bytes 32,43,…,34 on cycles t0+1…t0+16 with `core_rst`=1; the XOR of the shares of `ct_sh` equals 3925841d02dc09fbdc118597196a0b32.
- Same vector, REMASK=1, `rnd_in` random every cycle, random input masks. Required: the per-cycle XOR of the shares of `core_pt` equals the plain bytes 32,43,f6,…; each share on its own differs from the plain byte; unmasked ciphertext unchanged.
- SHARES=3, W=8, BYTES=16, random 3-share split of the same vector. Required: ciphertext XOR of the 3 shares = 3925841d…0b32.
- Core model never asserts `core_done`, TIMEOUT=64. Required: `err`=1 exactly 64 RUN cycles after `core_rst` falls, return to IDLE, `in_ready`=1; `err` clears on the next accept.
- Hold `out_ready`=0 for 20 cycles in HOLD while toggling `in_valid`. Required: `ct_sh` stable, `in_ready`=0, no new load; on the first `out_ready`=1, exactly one acceptance.
- Drive `rst`=0 during UNLOAD word 7. Required: all outputs at reset values immediately; the next full transaction completes correctly.
